// File: rtl/meter_pkg.sv
// Shared definitions for the parking-meter command scheduler:
// command op encodings, command amounts, button indices, source ids, FSM states.
package meter_pkg;

  // Command op encodings on cmd_op (2'b11 is reserved and never driven)
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  // Command amounts, in counter units
  localparam int AMT_ADD1  = 60;
  localparam int AMT_ADD2  = 120;
  localparam int AMT_ADD3  = 180;
  localparam int AMT_ADD4  = 300;
  localparam int AMT_LOAD1 = 16;
  localparam int AMT_LOAD2 = 150;
  localparam int AMT_DEC   = 1;

  // Button indices within btn_raw
  localparam int NUM_BTN  = 6;
  localparam int BTN_ADD1 = 0;
  localparam int BTN_ADD2 = 1;
  localparam int BTN_ADD3 = 2;
  localparam int BTN_ADD4 = 3;
  localparam int BTN_RST1 = 4;
  localparam int BTN_RST2 = 5;

  // Source id of the in-flight command: 0..5 are buttons, 6 is the tick
  localparam int         SRC_W    = 3;
  localparam logic [2:0] SRC_TICK = 3'd6;

  // Scheduler FSM states
  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_t;

  // Amount for an ADD button, indexed 0..3
  function automatic int add_amount(input logic [1:0] idx);
    case (idx)
      2'd0:    return AMT_ADD1;
      2'd1:    return AMT_ADD2;
      2'd2:    return AMT_ADD3;
      default: return AMT_ADD4;
    endcase
  endfunction

endpackage

// File: rtl/meter_btn_debounce.sv
// One front-panel button: 2-FF synchroniser, debounce counter, and a
// one-cycle pulse in the same cycle the debounced level rises.
// The debounced level only changes after DB_CYCLES consecutive cycles of the
// synced input disagreeing with it; releases produce no pulse.
module meter_btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Synchronise, count consecutive disagreeing cycles, flip level and flag rising edges
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          rise_reg  <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/meter_cmd_sched.sv
// Parking-meter command scheduler: debounces six buttons, generates the
// decrement tick and arbitrates everything into one valid/ready command
// stream so that only one agent ever writes the time counter.
// Optional feature: define METER_CMD_RR_EN for round-robin ADD selection;
// without it ADD buttons use fixed add1 > add2 > add3 > add4 priority.
module meter_cmd_sched
  import meter_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 100000000,
  parameter int AMT_W     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       btn_raw,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [AMT_W-1:0] cmd_amount,
  input  logic             cmd_ready,
  output logic             tick_ovf,
  output logic             busy
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pend_reg, pend_next;
  logic [DIV_W-1:0]   div_reg;
  logic               wrap;
  logic [1:0]         tick_pend_reg, tick_pend_next;
  logic               tick_ovf_reg;
  logic               tick_lost;
  logic               xfer;
  logic               dec_xfer;

  state_t             state_reg, state_next;
  logic               cmd_valid_reg, cmd_valid_next;
  logic [1:0]         cmd_op_reg, cmd_op_next;
  logic [AMT_W-1:0]   cmd_amount_reg, cmd_amount_next;
  logic [SRC_W-1:0]   win_reg, win_next;

  logic               sel_valid;
  logic [1:0]         sel_op;
  logic [AMT_W-1:0]   sel_amount;
  logic [SRC_W-1:0]   sel_src;
  logic               add_found;
  logic [1:0]         add_idx;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      meter_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw[gi]),
        .rise    (rise[gi])
      );
    end
  endgenerate

  assign xfer     = cmd_valid_reg & cmd_ready;
  assign dec_xfer = xfer && (win_reg == SRC_TICK);
  assign wrap     = (div_reg == DIV_W'(TICK_DIV - 1));

  // Tick divider free-runs 0..TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (wrap) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // Pending tick count: +1 on wrap, -1 on DEC transfer, saturating at 3.
  // A wrap coinciding with a DEC transfer frees a slot, so that tick is not lost.
  always_comb begin
    tick_pend_next = tick_pend_reg;
    tick_lost      = 1'b0;
    if (wrap && !dec_xfer) begin
      if (tick_pend_reg == 2'd3) begin
        tick_lost = 1'b1;
      end else begin
        tick_pend_next = tick_pend_reg + 2'd1;
      end
    end else if (!wrap && dec_xfer) begin
      tick_pend_next = tick_pend_reg - 2'd1;
    end
  end

  // Button pending flags: the winner clears on transfer, a LOAD transfer clears
  // every button flag; a rise in the same cycle still lands as a new request.
  always_comb begin
    pend_next = pend_reg;
    if (xfer && (win_reg != SRC_TICK)) begin
      if (cmd_op_reg == OP_LOAD) begin
        pend_next = '0;
      end else begin
        for (int i = 0; i < NUM_BTN; i++) begin
          if (win_reg == SRC_W'(i)) begin
            pend_next[i] = 1'b0;
          end
        end
      end
    end
    pend_next = pend_next | rise;
  end

  // Pending state and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg      <= '0;
      tick_pend_reg <= 2'd0;
      tick_ovf_reg  <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      tick_pend_reg <= tick_pend_next;
      if (tick_lost) begin
        tick_ovf_reg <= 1'b1;
      end
    end
  end

`ifdef METER_CMD_RR_EN
  logic [1:0] rr_ptr_reg;
  logic [1:0] rr_idx;

  // Round-robin ADD pick: first pending flag at or after the pointer
  always_comb begin
    add_found = 1'b0;
    add_idx   = 2'd0;
    rr_idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = rr_ptr_reg + 2'(k);
      if (pend_reg[rr_idx]) begin
        add_found = 1'b1;
        add_idx   = rr_idx;
      end
    end
  end

  // Pointer moves to one past the last granted ADD, only on an ADD transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= 2'd0;
    end else if (xfer && (cmd_op_reg == OP_ADD)) begin
      rr_ptr_reg <= win_reg[1:0] + 2'd1;
    end
  end
`else
  // Fixed ADD pick: lowest-index pending button wins
  always_comb begin
    add_found = 1'b0;
    add_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (pend_reg[k]) begin
        add_found = 1'b1;
        add_idx   = 2'(k);
      end
    end
  end
`endif

  // Request priority: LOAD (rst1 > rst2) > DEC > ADD
  always_comb begin
    sel_valid  = 1'b1;
    sel_op     = OP_ADD;
    sel_amount = AMT_W'(add_amount(add_idx));
    sel_src    = SRC_W'(add_idx);
    if (pend_reg[BTN_RST1]) begin
      sel_op     = OP_LOAD;
      sel_amount = AMT_W'(AMT_LOAD1);
      sel_src    = SRC_W'(BTN_RST1);
    end else if (pend_reg[BTN_RST2]) begin
      sel_op     = OP_LOAD;
      sel_amount = AMT_W'(AMT_LOAD2);
      sel_src    = SRC_W'(BTN_RST2);
    end else if (tick_pend_reg != 2'd0) begin
      sel_op     = OP_DEC;
      sel_amount = AMT_W'(AMT_DEC);
      sel_src    = SRC_TICK;
    end else if (!add_found) begin
      sel_valid = 1'b0;
    end
  end

  // FSM next state: latch a winner in IDLE, hold it in ISSUE until accepted
  always_comb begin
    state_next      = state_reg;
    cmd_valid_next  = cmd_valid_reg;
    cmd_op_next     = cmd_op_reg;
    cmd_amount_next = cmd_amount_reg;
    win_next        = win_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid) begin
          state_next      = ST_ISSUE;
          cmd_valid_next  = 1'b1;
          cmd_op_next     = sel_op;
          cmd_amount_next = sel_amount;
          win_next        = sel_src;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_next     = ST_IDLE;
          cmd_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        cmd_valid_next = 1'b0;
      end
    endcase
  end

  // FSM and presented-command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cmd_valid_reg  <= 1'b0;
      cmd_op_reg     <= OP_ADD;
      cmd_amount_reg <= '0;
      win_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_op_reg     <= cmd_op_next;
      cmd_amount_reg <= cmd_amount_next;
      win_reg        <= win_next;
    end
  end

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_op     = cmd_op_reg;
  assign cmd_amount = cmd_amount_reg;
  assign tick_ovf   = tick_ovf_reg;
  assign busy       = cmd_valid_reg | (|pend_reg) | (tick_pend_reg != 2'd0);

endmodule

// File: tb/tb_meter_cmd_sched.sv
// Directed bench for meter_cmd_sched with DB_CYCLES=4, TICK_DIV=50.
// A monitor logs every transfer; each test task checks outputs and the log.
module tb_meter_cmd_sched;

  localparam int DB  = 4;
  localparam int DIV = 50;
  localparam int AW  = 14;

  localparam logic [1:0] E_ADD  = 2'b00;
  localparam logic [1:0] E_LOAD = 2'b01;
  localparam logic [1:0] E_DEC  = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    btn_raw = 6'h00;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_amount;
  logic          cmd_ready = 1'b1;
  logic          tick_ovf;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [1:0]    q_op[$];
  logic [AW-1:0] q_amt[$];
  int            q_cyc[$];

  meter_cmd_sched #(.DB_CYCLES(DB), .TICK_DIV(DIV), .AMT_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_amount (cmd_amount),
    .cmd_ready  (cmd_ready),
    .tick_ovf   (tick_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transfer monitor: one line per accepted command
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && cmd_valid && cmd_ready) begin
      q_op.push_back(cmd_op);
      q_amt.push_back(cmd_amount);
      q_cyc.push_back(cyc);
      $display("xfer op=%0d amt=%0d cyc=%0d", cmd_op, cmd_amount, cyc);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_op.delete();
    q_amt.delete();
    q_cyc.delete();
  endtask

  // Reset for 3 cycles; returns on the negedge where rst has just dropped
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    btn_raw = 6'h00;
    cmd_ready = rdy;
    wait_n(3);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    wait_n(2);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_raw = 6'h3F;
    cmd_ready = 1'b1;
    wait_n(3);
    checks++;
    if ({cmd_valid, cmd_op, cmd_amount, tick_ovf, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b op=%0d amt=%0d ovf=%0b busy=%0b expected all 0",
               cmd_valid, cmd_op, cmd_amount, tick_ovf, busy);
    end
    clear_log();
    rst = 1'b0;
    wait_n(7);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_early_cmd: got valid=%0b expected 0", cmd_valid);
    end
    wait_n(1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== E_LOAD || cmd_amount !== 14'd16) begin
      errors++;
      $display("FAIL reset_first_cmd: got v=%0b op=%0d amt=%0d expected v=1 op=1 amt=16",
               cmd_valid, cmd_op, cmd_amount);
    end
    btn_raw = 6'h00;
    wait_n(15);
    checks++;
    if (q_op.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_load_clears_all: got xfers=%0d busy=%0b expected xfers=1 busy=0",
               q_op.size(), busy);
    end
  endtask

  task automatic test_single_press();
    do_reset(1'b1);
    btn_raw = 6'b000010;
    wait_n(7);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL press_latency_early: got valid=%0b expected 0", cmd_valid);
    end
    wait_n(1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== E_ADD || cmd_amount !== 14'd120) begin
      errors++;
      $display("FAIL press_latency: got v=%0b op=%0d amt=%0d expected v=1 op=0 amt=120",
               cmd_valid, cmd_op, cmd_amount);
    end
    wait_n(2);
    btn_raw = 6'h00;
    wait_n(20);
    checks++;
    if (q_op.size() != 1) begin
      errors++;
      $display("FAIL press_count: got %0d transfers expected 1", q_op.size());
    end else begin
      checks++;
      if (q_op[0] !== E_ADD || q_amt[0] !== 14'd120) begin
        errors++;
        $display("FAIL press_fields: got op=%0d amt=%0d expected op=0 amt=120", q_op[0], q_amt[0]);
      end
    end
    do_reset(1'b1);
    btn_raw = 6'b000001;
    wait_n(2);
    btn_raw = 6'h00;
    wait_n(20);
    checks++;
    if (q_op.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_ignored: got xfers=%0d busy=%0b expected 0 and 0", q_op.size(), busy);
    end
  endtask

  task automatic test_priority();
    do_reset(1'b0);
    btn_raw = 6'b100001;
    wait_n(10);
    btn_raw = 6'h00;
    wait_n(8);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== E_LOAD || cmd_amount !== 14'd150) begin
      errors++;
      $display("FAIL prio_load_first: got v=%0b op=%0d amt=%0d expected v=1 op=1 amt=150",
               cmd_valid, cmd_op, cmd_amount);
    end
    wait_n(37);
    checks++;
    if (cmd_op !== E_LOAD || cmd_amount !== 14'd150 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_hold_after_tick: got op=%0d amt=%0d busy=%0b expected op=1 amt=150 busy=1",
               cmd_op, cmd_amount, busy);
    end
    cmd_ready = 1'b1;
    wait_n(10);
    checks++;
    if (q_op.size() != 2) begin
      errors++;
      $display("FAIL prio_count: got %0d transfers expected 2", q_op.size());
    end else begin
      checks++;
      if (q_op[0] !== E_LOAD || q_amt[0] !== 14'd150 || q_op[1] !== E_DEC || q_amt[1] !== 14'd1) begin
        errors++;
        $display("FAIL prio_order: got %0d/%0d then %0d/%0d expected 1/150 then 2/1",
                 q_op[0], q_amt[0], q_op[1], q_amt[1]);
      end
      checks++;
      if (q_cyc[1] - q_cyc[0] != 2) begin
        errors++;
        $display("FAIL prio_spacing: got %0d cycles expected 2", q_cyc[1] - q_cyc[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    do_reset(1'b0);
    wait_n(60);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== E_DEC || cmd_amount !== 14'd1) begin
      errors++;
      $display("FAIL bp_dec_presented: got v=%0b op=%0d amt=%0d expected v=1 op=2 amt=1",
               cmd_valid, cmd_op, cmd_amount);
    end
    for (int i = 0; i < 135; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_op !== E_DEC || cmd_amount !== 14'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
    end
    checks++;
    if (tick_ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf_early: got tick_ovf=%0b expected 0", tick_ovf);
    end
    wait_n(10);
    checks++;
    if (tick_ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf_set: got tick_ovf=%0b expected 1", tick_ovf);
    end
    cmd_ready = 1'b1;
    wait_n(12);
    checks++;
    if (q_op.size() != 3) begin
      errors++;
      $display("FAIL bp_dec_count: got %0d transfers expected 3", q_op.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (q_op[i] !== E_DEC || q_amt[i] !== 14'd1) begin
          errors++;
          $display("FAIL bp_dec_fields[%0d]: got op=%0d amt=%0d expected op=2 amt=1", i, q_op[i], q_amt[i]);
        end
      end
      checks++;
      if (q_cyc[1] - q_cyc[0] != 2 || q_cyc[2] - q_cyc[1] != 2) begin
        errors++;
        $display("FAIL bp_back_to_back: got gaps %0d,%0d expected 2,2",
                 q_cyc[1] - q_cyc[0], q_cyc[2] - q_cyc[1]);
      end
    end
    checks++;
    if (tick_ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_after: got ovf=%0b busy=%0b expected ovf=1 busy=0", tick_ovf, busy);
    end
  endtask

  task automatic test_add_arb();
    logic [AW-1:0] exp_amt[5];
`ifdef METER_CMD_RR_EN
    exp_amt = '{14'd60, 14'd120, 14'd180, 14'd300, 14'd60};
`else
    exp_amt = '{14'd60, 14'd120, 14'd60, 14'd180, 14'd300};
`endif
    do_reset(1'b0);
    btn_raw = 6'b001111;
    wait_n(8);
    btn_raw = 6'h00;
    wait_n(4);
    pulse_ready();
    btn_raw = 6'b000001;
    wait_n(8);
    btn_raw = 6'h00;
    for (int i = 0; i < 4; i++) pulse_ready();
    checks++;
    if (q_op.size() != 5) begin
      errors++;
      $display("FAIL add_arb_count: got %0d transfers expected 5", q_op.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_op[i] !== E_ADD || q_amt[i] !== exp_amt[i]) begin
          errors++;
          $display("FAIL add_arb_grant[%0d]: got op=%0d amt=%0d expected op=0 amt=%0d",
                   i, q_op[i], q_amt[i], exp_amt[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL add_arb_idle: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset(1'b0);
    btn_raw = 6'b000100;
    wait_n(10);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_amount !== 14'd180) begin
      errors++;
      $display("FAIL mid_issue_setup: got v=%0b amt=%0d expected v=1 amt=180", cmd_valid, cmd_amount);
    end
    rst = 1'b1;
    btn_raw = 6'h00;
    wait_n(1);
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || cmd_amount !== 14'd0) begin
      errors++;
      $display("FAIL mid_issue_reset: got v=%0b busy=%0b amt=%0d expected 0 0 0",
               cmd_valid, busy, cmd_amount);
    end
    rst = 1'b0;
    wait_n(20);
    checks++;
    if (q_op.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_issue_no_xfer: got xfers=%0d busy=%0b expected 0 0", q_op.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_priority();
    test_backpressure();
    test_add_arb();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
